// File: rtl/rv_id_pkg.sv
// rtl/rv_id_pkg.sv - RV32I decode types, opcode/funct constants and immediate builder
package rv_id_pkg;

   typedef enum logic [4:0] {
      UOP_NOP, UOP_LUI, UOP_AUIPC, UOP_LD, UOP_ST, UOP_ALUI, UOP_ALU, UOP_MULDIV,
      UOP_JAL, UOP_JALR, UOP_BR, UOP_FENCE, UOP_FENCEI, UOP_CSR, UOP_ECALL,
      UOP_EBREAK, UOP_URET, UOP_SRET, UOP_MRET, UOP_WFI
   } uop_e;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z} imm_fmt_e;

   localparam logic [4:0] OP_LOAD    = 5'b00000;
   localparam logic [4:0] OP_MISCMEM = 5'b00011;
   localparam logic [4:0] OP_OPIMM   = 5'b00100;
   localparam logic [4:0] OP_AUIPC   = 5'b00101;
   localparam logic [4:0] OP_STORE   = 5'b01000;
   localparam logic [4:0] OP_OP      = 5'b01100;
   localparam logic [4:0] OP_LUI     = 5'b01101;
   localparam logic [4:0] OP_BRANCH  = 5'b11000;
   localparam logic [4:0] OP_JALR    = 5'b11001;
   localparam logic [4:0] OP_JAL     = 5'b11011;
   localparam logic [4:0] OP_SYSTEM  = 5'b11100;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;
   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SR     = 3'b101;
   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [2:0] F3_FENCE  = 3'b000;
   localparam logic [2:0] F3_FENCEI = 3'b001;
   localparam logic [2:0] F3_PRIV   = 3'b000;

   localparam logic [31:0] SYS_ECALL  = 32'h0000_0073;
   localparam logic [31:0] SYS_EBREAK = 32'h0010_0073;
   localparam logic [31:0] SYS_URET   = 32'h0020_0073;
   localparam logic [31:0] SYS_SRET   = 32'h1020_0073;
   localparam logic [31:0] SYS_MRET   = 32'h3020_0073;
   localparam logic [31:0] SYS_WFI    = 32'h1050_0073;

   typedef struct packed {
      uop_e        uop;
      logic [2:0]  alu_code;
      logic        alu_sub;
      logic [31:0] imm;
      logic [11:0] csr_adr;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rs1_vld;
      logic        rs2_vld;
      logic [4:0]  rd;
      logic        wbk;
      logic        illegal;
   } dec_t;

   function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
      case (fmt)
         IMM_I:   imm_gen = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm_gen = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm_gen = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm_gen = {inst[31:12], 12'b0};
         IMM_J:   imm_gen = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         IMM_Z:   imm_gen = {27'b0, inst[19:15]};
         default: imm_gen = 32'b0;
      endcase
   endfunction

endpackage

// File: rtl/id_decode_core.sv
// rtl/id_decode_core.sv - combinational RV32I(+M/Zicsr/Zifencei) instruction decoder
module id_decode_core
   import rv_id_pkg::*;
#(
   parameter int EN_M      = 0,
   parameter int EN_CSR    = 1,
   parameter int EN_FENCEI = 1
)(
   input  logic [31:0] inst,
   output dec_t        dec
);

   logic [4:0] op, rd, rs1, rs2;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       ill, has_rd, has_f3;
   imm_fmt_e   fmt;
   dec_t       d;

   assign op  = inst[6:2];
   assign rd  = inst[11:7];
   assign f3  = inst[14:12];
   assign rs1 = inst[19:15];
   assign rs2 = inst[24:20];
   assign f7  = inst[31:25];

   always_comb begin
      d      = '0;
      ill    = 1'b0;
      has_rd = 1'b0;
      has_f3 = 1'b1;
      fmt    = IMM_NONE;
      case (op)
         OP_LUI:   begin d.uop = UOP_LUI;   fmt = IMM_U; has_rd = 1'b1; has_f3 = 1'b0; end
         OP_AUIPC: begin d.uop = UOP_AUIPC; fmt = IMM_U; has_rd = 1'b1; has_f3 = 1'b0; end
         OP_JAL:   begin d.uop = UOP_JAL;   fmt = IMM_J; has_rd = 1'b1; has_f3 = 1'b0; end
         OP_JALR: begin
            d.uop = UOP_JALR; fmt = IMM_I; has_rd = 1'b1; d.rs1_vld = 1'b1;
            ill = (f3 != F3_ADD);
         end
         OP_BRANCH: begin
            d.uop = UOP_BR; fmt = IMM_B; d.rs1_vld = 1'b1; d.rs2_vld = 1'b1;
            ill = (f3[2:1] == 2'b01);
         end
         OP_LOAD: begin
            d.uop = UOP_LD; fmt = IMM_I; has_rd = 1'b1; d.rs1_vld = 1'b1;
            ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OP_STORE: begin
            d.uop = UOP_ST; fmt = IMM_S; d.rs1_vld = 1'b1; d.rs2_vld = 1'b1;
            ill = f3[2] || (f3 == 3'b011);
         end
         OP_OPIMM: begin
            d.uop = UOP_ALUI; fmt = IMM_I; has_rd = 1'b1; d.rs1_vld = 1'b1;
            // Shift-immediates reuse the upper immediate bits as funct7; shamt[5] is reserved.
            if (f3 == F3_SLL) ill = (f7 != F7_BASE);
            if (f3 == F3_SR) begin
               ill       = (f7 != F7_BASE) && (f7 != F7_ALT);
               d.alu_sub = (f7 == F7_ALT);
            end
         end
         OP_OP: begin
            d.uop = UOP_ALU; has_rd = 1'b1; d.rs1_vld = 1'b1; d.rs2_vld = 1'b1;
            if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) d.alu_sub = 1'b1;
            else if (f7 == F7_MULDIV && EN_M != 0)              d.uop = UOP_MULDIV;
            else if (f7 != F7_BASE)                             ill = 1'b1;
         end
         OP_MISCMEM: begin
            if (f3 == F3_FENCE) begin
               d.uop = UOP_FENCE;
               ill   = (rd != 5'd0) || (rs1 != 5'd0);
            end else if (f3 == F3_FENCEI && EN_FENCEI != 0) begin
               d.uop = UOP_FENCEI;
               ill   = (inst[31:20] != 12'd0) || (rd != 5'd0) || (rs1 != 5'd0);
            end else begin
               ill = 1'b1;
            end
         end
         OP_SYSTEM: begin
            if (EN_CSR == 0) begin
               ill = 1'b1;
            end else if (f3 == F3_PRIV) begin
               case (inst)
                  SYS_ECALL:  d.uop = UOP_ECALL;
                  SYS_EBREAK: d.uop = UOP_EBREAK;
                  SYS_URET:   d.uop = UOP_URET;
                  SYS_SRET:   d.uop = UOP_SRET;
                  SYS_MRET:   d.uop = UOP_MRET;
                  SYS_WFI:    d.uop = UOP_WFI;
                  default:    ill = 1'b1;
               endcase
            end else if (f3 == 3'b100) begin
               ill = 1'b1;
            end else begin
               d.uop     = UOP_CSR;
               has_rd    = 1'b1;
               d.csr_adr = inst[31:20];
               d.rs1_vld = ~f3[2];
               fmt       = f3[2] ? IMM_Z : IMM_NONE;
            end
         end
         default: ill = 1'b1;
      endcase

      d.alu_code = has_f3 ? f3 : 3'b000;
      d.imm      = imm_gen(inst, fmt);
      d.rs1      = d.rs1_vld ? rs1 : 5'd0;
      d.rs2      = d.rs2_vld ? rs2 : 5'd0;
      d.rd       = has_rd ? rd : 5'd0;
      d.wbk      = has_rd && (rd != 5'd0);

      if (ill || inst[1:0] != 2'b11) begin
         d         = '0;
         d.illegal = 1'b1;
      end
   end

   assign dec = d;

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: IF handshake, ID->EX register, load-use bubbles, flush
module id_stage
   import rv_id_pkg::*;
#(
   parameter int PC_W           = 32,
   parameter int EN_M           = 0,
   parameter int EN_CSR         = 1,
   parameter int EN_FENCEI      = 1,
   parameter int LD_USE_BUBBLES = 1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     if_inst,
   input  logic [PC_W-1:0] if_pc,
   output logic            id_ready,
   input  logic            flush,
   input  logic            ex_ready,
   output logic            ex_valid,
   output logic [4:0]      ex_cmd,
   output logic [2:0]      ex_alu_code,
   output logic            ex_alu_sub,
   output logic [31:0]     ex_imm,
   output logic [11:0]     ex_csr_adr,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic            ex_rs1_vld,
   output logic            ex_rs2_vld,
   output logic [4:0]      ex_rd,
   output logic            ex_wbk,
   output logic [PC_W-1:0] ex_pc,
   output logic            ex_illegal
);

   typedef enum logic {ST_RUN, ST_BUBBLE} state_e;

   state_e     state_q;
   logic [1:0] bub_cnt;
   dec_t       dec;
   logic       ex_hold, ld_in_ex, hazard, bubbling;

   id_decode_core #(.EN_M(EN_M), .EN_CSR(EN_CSR), .EN_FENCEI(EN_FENCEI)) u_decode (
      .inst (if_inst),
      .dec  (dec)
   );

   assign ex_hold  = ex_valid && !ex_ready;
   assign ld_in_ex = ex_valid && (ex_cmd == 5'(UOP_LD)) && (ex_rd != 5'd0);
   assign hazard   = if_valid && ld_in_ex &&
                     ((dec.rs1_vld && dec.rs1 == ex_rd) || (dec.rs2_vld && dec.rs2 == ex_rd));
   assign bubbling = (state_q == ST_BUBBLE) && (bub_cnt != 2'd0);

   always_comb begin
      id_ready = 1'b1;
      if (rst)                             id_ready = 1'b0;
      else if (flush)                      id_ready = 1'b1;
      else if (ex_hold || bubbling || hazard) id_ready = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         bub_cnt     <= 2'd0;
         ex_valid    <= 1'b0;
         ex_cmd      <= 5'(UOP_NOP);
         ex_alu_code <= '0;
         ex_alu_sub  <= 1'b0;
         ex_imm      <= '0;
         ex_csr_adr  <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rs1_vld  <= 1'b0;
         ex_rs2_vld  <= 1'b0;
         ex_rd       <= '0;
         ex_wbk      <= 1'b0;
         ex_pc       <= '0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         state_q  <= ST_RUN;
         bub_cnt  <= 2'd0;
         ex_valid <= 1'b0;
      end else if (ex_hold) begin
         state_q <= state_q;
      end else if (bubbling) begin
         bub_cnt  <= bub_cnt - 2'd1;
         ex_valid <= 1'b0;
      end else if (hazard) begin
         // The load leaves EX this cycle; the dependent op waits LD_USE_BUBBLES cycles.
         state_q  <= ST_BUBBLE;
         bub_cnt  <= 2'(LD_USE_BUBBLES - 1);
         ex_valid <= 1'b0;
      end else begin
         state_q  <= ST_RUN;
         ex_valid <= if_valid;
         if (if_valid) begin
            ex_cmd      <= dec.uop;
            ex_alu_code <= dec.alu_code;
            ex_alu_sub  <= dec.alu_sub;
            ex_imm      <= dec.imm;
            ex_csr_adr  <= dec.csr_adr;
            ex_rs1      <= dec.rs1;
            ex_rs2      <= dec.rs2;
            ex_rs1_vld  <= dec.rs1_vld;
            ex_rs2_vld  <= dec.rs2_vld;
            ex_rd       <= dec.rd;
            ex_wbk      <= dec.wbk;
            ex_pc       <= if_pc;
            ex_illegal  <= dec.illegal;
         end
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage, two parameterisations side by side
module tb_id_stage;
   import rv_id_pkg::*;

   typedef struct packed {
      logic [4:0]  cmd;
      logic [2:0]  code;
      logic        sub;
      logic [31:0] imm;
      logic [11:0] csr;
      logic [4:0]  rd;
      logic        wbk;
      logic        r1v;
      logic        r2v;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        ill;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid [2];
   logic [31:0] if_inst [2];
   logic [31:0] if_pc [2];
   logic        id_ready [2];
   logic        flush [2];
   logic        ex_ready [2];
   logic        ex_valid [2];
   logic [4:0]  ex_cmd [2];
   logic [2:0]  ex_alu_code [2];
   logic        ex_alu_sub [2];
   logic [31:0] ex_imm [2];
   logic [11:0] ex_csr_adr [2];
   logic [4:0]  ex_rs1 [2];
   logic [4:0]  ex_rs2 [2];
   logic        ex_rs1_vld [2];
   logic        ex_rs2_vld [2];
   logic [4:0]  ex_rd [2];
   logic        ex_wbk [2];
   logic [31:0] ex_pc [2];
   logic        ex_illegal [2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_cyc [2];
   int   prev_cyc [2];
   logic [31:0] pc_n [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   id_stage #(.PC_W(32), .EN_M(0), .EN_CSR(1), .EN_FENCEI(1), .LD_USE_BUBBLES(1)) dut0 (
      .clk(clk), .rst(rst), .if_valid(if_valid[0]), .if_inst(if_inst[0]), .if_pc(if_pc[0]),
      .id_ready(id_ready[0]), .flush(flush[0]), .ex_ready(ex_ready[0]), .ex_valid(ex_valid[0]),
      .ex_cmd(ex_cmd[0]), .ex_alu_code(ex_alu_code[0]), .ex_alu_sub(ex_alu_sub[0]),
      .ex_imm(ex_imm[0]), .ex_csr_adr(ex_csr_adr[0]), .ex_rs1(ex_rs1[0]), .ex_rs2(ex_rs2[0]),
      .ex_rs1_vld(ex_rs1_vld[0]), .ex_rs2_vld(ex_rs2_vld[0]), .ex_rd(ex_rd[0]),
      .ex_wbk(ex_wbk[0]), .ex_pc(ex_pc[0]), .ex_illegal(ex_illegal[0])
   );

   id_stage #(.PC_W(32), .EN_M(1), .EN_CSR(0), .EN_FENCEI(1), .LD_USE_BUBBLES(3)) dut1 (
      .clk(clk), .rst(rst), .if_valid(if_valid[1]), .if_inst(if_inst[1]), .if_pc(if_pc[1]),
      .id_ready(id_ready[1]), .flush(flush[1]), .ex_ready(ex_ready[1]), .ex_valid(ex_valid[1]),
      .ex_cmd(ex_cmd[1]), .ex_alu_code(ex_alu_code[1]), .ex_alu_sub(ex_alu_sub[1]),
      .ex_imm(ex_imm[1]), .ex_csr_adr(ex_csr_adr[1]), .ex_rs1(ex_rs1[1]), .ex_rs2(ex_rs2[1]),
      .ex_rs1_vld(ex_rs1_vld[1]), .ex_rs2_vld(ex_rs2_vld[1]), .ex_rd(ex_rd[1]),
      .ex_wbk(ex_wbk[1]), .ex_pc(ex_pc[1]), .ex_illegal(ex_illegal[1])
   );

   function automatic exp_t mk(input uop_e c, input logic [2:0] code, input logic sub,
                               input logic [31:0] imm, input logic [4:0] rd, input logic wbk,
                               input logic r1v, input logic r2v, input logic [4:0] r1,
                               input logic [4:0] r2);
      exp_t e;
      e = '0;
      e.cmd = c; e.code = code; e.sub = sub; e.imm = imm; e.rd = rd; e.wbk = wbk;
      e.r1v = r1v; e.r2v = r2v; e.r1 = r1; e.r2 = r2;
      return e;
   endfunction

   function automatic exp_t ill_e();
      exp_t e;
      e = '0;
      e.ill = 1'b1;
      return e;
   endfunction

   function automatic logic [127:0] ex_all(input int d);
      return 128'({ex_valid[d], ex_cmd[d], ex_alu_code[d], ex_alu_sub[d], ex_imm[d],
                   ex_csr_adr[d], ex_rs1[d], ex_rs2[d], ex_rs1_vld[d], ex_rs2_vld[d],
                   ex_rd[d], ex_wbk[d], ex_pc[d], ex_illegal[d]});
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic check_out(input int d);
      exp_t e, a;
      n_chk++;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
         n_fail++;
         $display("FAIL unexpected_bundle dut%0d: got pc %h, want no bundle", d, ex_pc[d]);
         return;
      end
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      a.cmd = ex_cmd[d]; a.code = ex_alu_code[d]; a.sub = ex_alu_sub[d]; a.imm = ex_imm[d];
      a.csr = ex_csr_adr[d]; a.rd = ex_rd[d]; a.wbk = ex_wbk[d]; a.r1v = ex_rs1_vld[d];
      a.r2v = ex_rs2_vld[d]; a.r1 = ex_rs1[d]; a.r2 = ex_rs2[d]; a.ill = ex_illegal[d];
      a.pc = ex_pc[d];
      prev_cyc[d] = last_cyc[d];
      last_cyc[d] = cyc;
      if (a !== e) begin
         n_fail++;
         $display("FAIL bundle dut%0d pc %h: got %h want %h", d, e.pc, a, e);
      end
   endtask

   // Monitor: a bundle is consumed on the next edge whenever valid and ready are both high.
   always begin
      @(negedge clk);
      #3;
      if (!rst) begin
         for (int d = 0; d < 2; d++)
            if (ex_valid[d] && ex_ready[d]) check_out(d);
      end
   end

   task automatic send(input int d, input logic [31:0] inst, input exp_t e, output int stalls);
      stalls = 0;
      @(negedge clk);
      if_valid[d] = 1'b1;
      if_inst[d]  = inst;
      if_pc[d]    = pc_n[d];
      e.pc        = pc_n[d];
      forever begin
         #1;
         if (id_ready[d]) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            break;
         end
         stalls++;
         if (stalls > 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: got no id_ready, want accept of %h", d, inst);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      if_valid[d] = 1'b0;
      pc_n[d] = pc_n[d] + 32'd4;
   endtask

   task automatic drain(input int d);
      int left;
      left = (d == 0) ? q0.size() : q1.size();
      for (int i = 0; i < 50 && left != 0; i++) begin
         @(negedge clk);
         #4;
         left = (d == 0) ? q0.size() : q1.size();
      end
      if (left != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout dut%0d: got %0d pending, want 0", d, left);
      end
   endtask

   task automatic run_vectors(input int d, input int bubbles);
      int   s;
      exp_t e;
      send(d, 32'h0050_0093, mk(UOP_ALUI, 3'd0, 1'b0, 32'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0), s);
      send(d, 32'h0000_A103, mk(UOP_LD, 3'd2, 1'b0, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0), s);
      send(d, 32'h0011_01B3, mk(UOP_ALU, 3'd0, 1'b0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd2, 5'd1), s);
      check($sformatf("load_use_stalls dut%0d", d), 128'(s), 128'(bubbles));
      drain(d);
      check($sformatf("load_use_gap dut%0d", d), 128'(last_cyc[d] - prev_cyc[d]), 128'(bubbles + 1));
      if (d == 0) e = ill_e();
      else        e = mk(UOP_MULDIV, 3'd0, 1'b0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2);
      send(d, 32'h0220_81B3, e, s);
      if (d == 0) e = mk(UOP_ECALL, 3'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      else        e = ill_e();
      send(d, 32'h0000_0073, e, s);
      send(d, 32'hFFFF_FFFF, ill_e(), s);
      send(d, 32'h0210_9093, ill_e(), s);
      send(d, 32'h0000_0013, mk(UOP_ALUI, 3'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0), s);
      send(d, 32'h0020_A423, mk(UOP_ST, 3'd2, 1'b0, 32'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2), s);
      send(d, 32'hFE20_8EE3, mk(UOP_BR, 3'd0, 1'b0, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2), s);
      send(d, 32'h1234_52B7, mk(UOP_LUI, 3'd0, 1'b0, 32'h1234_5000, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0), s);
      send(d, 32'h0080_00EF, mk(UOP_JAL, 3'd0, 1'b0, 32'd8, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0), s);
      send(d, 32'h4020_8233, mk(UOP_ALU, 3'd0, 1'b1, 32'd0, 5'd4, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2), s);
      if (d == 0) begin
         e = mk(UOP_CSR, 3'd1, 1'b0, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0);
         e.csr = 12'h300;
      end else begin
         e = ill_e();
      end
      send(d, 32'h3000_92F3, e, s);
      drain(d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, want finish");
      $fatal(1);
   end

   initial begin
      int       s;
      logic [31:0] held_pc;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         if_valid[d] = 1'b0; if_inst[d] = '0; if_pc[d] = '0;
         flush[d] = 1'b0; ex_ready[d] = 1'b1;
         last_cyc[d] = 0; prev_cyc[d] = 0;
      end
      pc_n[0] = 32'h0000_0100;
      pc_n[1] = 32'h0000_0200;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_outputs dut%0d", d), ex_all(d), 128'd0);
         check($sformatf("reset_id_ready dut%0d", d), 128'(id_ready[d]), 128'd0);
      end
      rst = 1'b0;

      run_vectors(0, 1);
      run_vectors(1, 3);

      // EX back-pressure on dut0: the first bundle must stay put while the next word waits.
      @(negedge clk);
      ex_ready[0] = 1'b0;
      held_pc = pc_n[0];
      send(0, 32'h0050_0093, mk(UOP_ALUI, 3'd0, 1'b0, 32'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0), s);
      @(negedge clk);
      if_valid[0] = 1'b1; if_inst[0] = 32'h1234_52B7; if_pc[0] = pc_n[0];
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("hold_cycle%0d", i),
               128'({id_ready[0], ex_valid[0], ex_cmd[0], ex_imm[0], ex_pc[0]}),
               128'({1'b0, 1'b1, 5'(UOP_ALUI), 32'd5, held_pc}));
         @(negedge clk);
      end
      if_valid[0] = 1'b0;
      ex_ready[0] = 1'b1;
      send(0, 32'h1234_52B7, mk(UOP_LUI, 3'd0, 1'b0, 32'h1234_5000, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0), s);
      drain(0);

      // Flush during a load-use bubble on dut1: the dependent add must vanish.
      send(1, 32'h0000_A103, mk(UOP_LD, 3'd2, 1'b0, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0), s);
      @(negedge clk);
      if_valid[1] = 1'b1; if_inst[1] = 32'h0011_01B3; if_pc[1] = pc_n[1];
      #1;
      check("flush_hazard_stall", 128'(id_ready[1]), 128'd0);
      @(negedge clk);
      flush[1] = 1'b1;
      #1;
      check("flush_id_ready", 128'(id_ready[1]), 128'd1);
      @(negedge clk);
      flush[1] = 1'b0;
      if_valid[1] = 1'b0;
      pc_n[1] = pc_n[1] + 32'd4;
      #1;
      check("after_flush", 128'({ex_valid[1], id_ready[1]}), 128'(2'b01));
      send(1, 32'h0050_0093, mk(UOP_ALUI, 3'd0, 1'b0, 32'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0), s);
      check("after_flush_stalls", 128'(s), 128'd0);
      drain(1);

      // Reset mid-stream on dut0 while a bundle sits in EX.
      @(negedge clk);
      ex_ready[0] = 1'b0;
      send(0, 32'h0080_00EF, mk(UOP_JAL, 3'd0, 1'b0, 32'd8, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0), s);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_id_ready", 128'(id_ready[0]), 128'd0);
      @(negedge clk);
      #1;
      check("midstream_reset_outputs", ex_all(0), 128'd0);
      q0.delete();
      rst = 1'b0;
      ex_ready[0] = 1'b1;
      send(0, 32'h0000_0013, mk(UOP_ALUI, 3'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0), s);
      drain(0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
